// File: rtl/pe_grid_accum.sv
// Row x column grid of processing elements. Each PE combines its row and
// column operands, then accumulates the result through a three-stage pipeline.
// A registered read port returns any one accumulator by flat index.
module pe_grid_accum #(
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned NUM_COLS = 16,
  parameter int unsigned DATA_W   = 34,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned ADDR_W   = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_valid,
  input  logic [NUM_ROWS-1:0][DATA_W-1:0]  i_row_val,
  input  logic [NUM_COLS-1:0][DATA_W-1:0]  i_col_val,
  input  logic [1:0]                       i_mode,
  input  logic                             i_clear,
  input  logic                             i_rd_req,
  input  logic [ADDR_W-1:0]                i_rd_addr,
  output logic                             o_rd_valid,
  output logic [ACC_W-1:0]                 o_rd_data,
  output logic                             o_rd_err,
  output logic                             o_ovf,
  output logic                             o_busy
);

  localparam int unsigned NUM_PES  = NUM_ROWS * NUM_COLS;
  localparam int unsigned RD_DEPTH = 1 << ADDR_W;
  localparam logic [1:0]  MODE_HOLD = 2'd3;

  // Shared pipeline control: one valid/mode per stage for the whole grid
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [1:0]       mode_q, mode_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;
  logic [ACC_W-1:0] rd_data_q, rd_data_d;

  logic [NUM_PES-1:0] pe_carry_c;
  logic [ACC_W-1:0]   acc_all [NUM_PES];
  logic [ACC_W-1:0]   rd_arr  [RD_DEPTH];
  logic [RD_DEPTH-1:0] addr_ok;

  // Per-PE datapath: S1 operand combine, S2 term select, S3 accumulate
  for (genvar gr = 0; gr < NUM_ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
      localparam int unsigned P = gr * NUM_COLS + gc;

      logic [DATA_W-1:0] sum_q, sum_d;
      logic [DATA_W-1:0] prod_q, prod_d;
      logic [ACC_W-1:0]  term_q, term_d;
      logic [ACC_W-1:0]  acc_q, acc_d;
      logic [ACC_W:0]    add_c;
      logic              carry_c;

      // Next-state for this PE's stage registers
      always_comb begin
        sum_d   = sum_q;
        prod_d  = prod_q;
        term_d  = term_q;
        acc_d   = acc_q;
        add_c   = {1'b0, acc_q} + {1'b0, term_q};
        carry_c = v2_q & add_c[ACC_W];
        if (i_valid) begin
          sum_d  = i_row_val[gr] + i_col_val[gc];
          prod_d = i_row_val[gr] * i_col_val[gc];
        end
        if (v1_q) begin
          case (mode_q)
            2'd0:    term_d = ACC_W'(sum_q ^ prod_q);
            2'd1:    term_d = ACC_W'(sum_q);
            default: term_d = ACC_W'(prod_q);
          endcase
        end
        if (v2_q) begin
          acc_d = ((SATURATE != 0) && add_c[ACC_W]) ? {ACC_W{1'b1}} : add_c[ACC_W-1:0];
        end
        if (i_clear) begin
          acc_d = '0;
        end
      end

      // PE stage registers
      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          sum_q  <= '0;
          prod_q <= '0;
          term_q <= '0;
          acc_q  <= '0;
        end else begin
          sum_q  <= sum_d;
          prod_q <= prod_d;
          term_q <= term_d;
          acc_q  <= acc_d;
        end
      end

      assign pe_carry_c[P] = carry_c;
      assign acc_all[P]    = acc_q;
    end
  end

  // Read mux padded to the full address space; unused slots flag an error
  for (genvar gi = 0; gi < RD_DEPTH; gi++) begin : g_rd
    if (gi < NUM_PES) begin : g_hit
      assign rd_arr[gi]  = acc_all[gi];
      assign addr_ok[gi] = 1'b1;
    end else begin : g_miss
      assign rd_arr[gi]  = '0;
      assign addr_ok[gi] = 1'b0;
    end
  end

  // Control next-state: valids, sticky overflow, busy and read port
  always_comb begin
    v1_d       = i_valid;
    mode_d     = mode_q;
    v2_d       = v1_q && (mode_q != MODE_HOLD);
    ovf_d      = ovf_q | (|pe_carry_c);
    rd_valid_d = i_rd_req;
    rd_err_d   = 1'b0;
    rd_data_d  = rd_data_q;
    if (i_valid) begin
      mode_d = i_mode;
    end
    if (i_clear) begin
      v2_d  = 1'b0;
      ovf_d = 1'b0;
    end
    busy_d = v1_d | v2_d;
    if (i_rd_req) begin
      rd_err_d  = ~addr_ok[i_rd_addr];
      rd_data_d = addr_ok[i_rd_addr] ? rd_arr[i_rd_addr] : '0;
    end
  end

  // Control registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      mode_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      mode_q     <= mode_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_err   = rd_err_q;
  assign o_ovf      = ovf_q;
  assign o_busy     = busy_q;

endmodule
